// File: rtl/nios_pio_fifo_out.sv
// Avalon-MM output PIO with a small word FIFO feeding a valid/ready consumer.
// Build with NIOS_PIO_FIFO_OUT_IRQ_EN defined to include IRQ_MASK and irq.
module nios_pio_fifo_out #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              irq
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_STAT = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_EVNT = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [LVL_W-1:0]  level;
    logic [1:0]        ev;
    logic [1:0]        ev_set;
    logic [1:0]        ev_clr;
    logic [1:0]        irq_mask;

    logic wr;
    logic push_req;
    logic push_ok;
    logic pop;
    logic flush;
    logic empty;
    logic full;
    logic unused_wd;

    assign unused_wd = ^writedata;

    assign wr       = chipselect && !write_n;
    assign push_req = wr && (address == A_DATA);
    assign flush    = wr && (address == A_STAT) && writedata[0];
    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(DEPTH));
    assign out_valid = !empty;
    assign pop      = out_valid && out_ready;
    assign push_ok  = push_req && !full && !flush;

    // full is the pre-edge value, so a same-cycle pop never rescues a push
    assign ev_set[1] = push_req && full && !flush;
    assign ev_set[0] = pop && !push_ok && !flush
                     && (level == LVL_W'(1));
    assign ev_clr    = (wr && (address == A_EVNT))
                     ? writedata[1:0] : 2'b00;

    assign out_port = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= writedata[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            level <= level + LVL_W'(push_ok) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev <= 2'b00;
        end else begin
            ev <= (ev & ~ev_clr) | ev_set;
        end
    end

`ifdef NIOS_PIO_FIFO_OUT_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= 2'b00;
        end else if (wr && (address == A_MASK)) begin
            irq_mask <= writedata[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(ev & irq_mask);
        end
    end
`else
    assign irq_mask = 2'b00;
    assign irq      = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        unique case (address)
            A_DATA: readdata[DATA_W-1:0] = out_port;
            A_STAT: begin
                readdata[0]          = empty;
                readdata[1]          = full;
                readdata[8 +: LVL_W] = level;
            end
            A_MASK: readdata[1:0] = irq_mask;
            A_EVNT: readdata[1:0] = ev;
            default: readdata = '0;
        endcase
    end

endmodule
